// File: rtl/mvu_job_ctrl_if.sv
// rtl/mvu_job_ctrl_if.sv - job request/status bundle between a host (master) and mvu_job_ctrl (slave)
interface mvu_job_ctrl_if #(
   parameter int BPREC = 6,
   parameter int BCNT  = 15
);
   logic              start;
   logic              abort;
   logic [BCNT-1:0]   countdown;
   logic [BPREC-1:0]  iprecision;
   logic [BPREC-1:0]  wprecision;
   logic              stall;
   logic              agu_clr;
   logic              agu_en;
   logic [BPREC-1:0]  iprec_q;
   logic [BPREC-1:0]  wprec_q;
   logic              busy;
   logic              done;
   logic [15:0]       perf_stall_cnt;

   modport master (
      output start, abort, countdown, iprecision, wprecision, stall,
      input  agu_clr, agu_en, iprec_q, wprec_q, busy, done, perf_stall_cnt
   );

   modport slave (
      input  start, abort, countdown, iprecision, wprecision, stall,
      output agu_clr, agu_en, iprec_q, wprec_q, busy, done, perf_stall_cnt
   );
endinterface

// File: rtl/mvu_job_ctrl.sv
// rtl/mvu_job_ctrl.sv - MVU job sequencer (IDLE/LOAD/RUN/DRAIN/DONE); MVU_JOB_CTRL_PERFCNT_EN adds the stall counter
module mvu_job_ctrl #(
   parameter int BPREC     = 6,
   parameter int BCNT      = 15,
   parameter int DRAIN_LAT = 3
) (
   input  logic           clk,
   input  logic           clr,
   mvu_job_ctrl_if.slave  job
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int DW = (DRAIN_LAT < 2) ? 1 : $clog2(DRAIN_LAT + 1);

   logic [2:0]        r_state;
   logic [BCNT-1:0]   r_step_cnt;
   logic [DW-1:0]     r_drain_cnt;
   logic [BPREC-1:0]  r_iprec;
   logic [BPREC-1:0]  r_wprec;

   logic w_active;
   logic w_abort;
   logic w_accept;
   logic w_step;

   // abort only matters while a job is actually in flight
   assign w_active = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_abort  = w_active && job.abort;
   assign w_accept = (r_state == S_IDLE) && job.start;
   assign w_step   = (r_state == S_RUN) && !job.stall && !w_abort && !clr;

   // job sequencing, step/drain counting and precision latching
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= S_IDLE;
         r_step_cnt  <= '0;
         r_drain_cnt <= '0;
         r_iprec     <= '0;
         r_wprec     <= '0;
      end else if (w_abort) begin
         r_state     <= S_IDLE;
         r_step_cnt  <= '0;
         r_drain_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_step_cnt <= job.countdown;
                  r_iprec    <= job.iprecision;
                  r_wprec    <= job.wprecision;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_state <= (r_step_cnt != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
               if (w_step) begin
                  r_step_cnt <= r_step_cnt - BCNT'(1);
                  if (r_step_cnt == BCNT'(1)) begin
                     if (DRAIN_LAT == 0) begin
                        r_state <= S_DONE;
                     end else begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= DW'(DRAIN_LAT);
                     end
                  end
               end
            end
            S_DRAIN: begin
               // stall is deliberately ignored: the pipeline drains on its own
               if (r_drain_cnt != '0) begin
                  r_drain_cnt <= r_drain_cnt - DW'(1);
               end
               if (r_drain_cnt <= DW'(1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MVU_JOB_CTRL_PERFCNT_EN
   logic [15:0] r_perf_cnt;

   // saturating count of stalled RUN cycles, restarted by each accepted job
   always_ff @(posedge clk) begin
      if (clr) begin
         r_perf_cnt <= '0;
      end else if (w_accept) begin
         r_perf_cnt <= '0;
      end else if ((r_state == S_RUN) && job.stall && !w_abort && (r_perf_cnt != 16'hFFFF)) begin
         r_perf_cnt <= r_perf_cnt + 16'd1;
      end
   end

   assign job.perf_stall_cnt = r_perf_cnt;
`else
   assign job.perf_stall_cnt = 16'd0;
`endif

   // address generator is cleared with the controller, at job load and on abort
   assign job.agu_clr = clr || (r_state == S_LOAD) || w_abort;
   assign job.agu_en  = w_step;
   assign job.busy    = (r_state != S_IDLE);
   assign job.done    = (r_state == S_DONE);
   assign job.iprec_q = r_iprec;
   assign job.wprec_q = r_wprec;
endmodule

// File: doc/mvu_job_ctrl.md
MVU_JOB_CTRL -- requirements
Module: mvu_job_ctrl

Interface
REQ-001 The block SHALL have parameter BPREC, default 6, the precision field width.
REQ-002 The block SHALL have parameter BCNT, default 15, the job step-count width.
REQ-003 The block SHALL have parameter DRAIN_LAT, default 3, the number of datapath pipeline drain cycles after the last step.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: job start request, sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels the active job.
REQ-008 The block SHALL have port countdown, input, BCNT bits: number of address-generator steps in the job.
REQ-009 The block SHALL have ports iprecision and wprecision, input, BPREC bits each: job precisions.
REQ-010 The block SHALL have port stall, input, 1 bit: downstream back-pressure that freezes stepping.
REQ-011 The block SHALL have port agu_clr, output, 1 bit: clear to the address generator.
REQ-012 The block SHALL have port agu_en, output, 1 bit: step enable to the address generator.
REQ-013 The block SHALL have ports iprec_q and wprec_q, output, BPREC bits each: latched precisions, held stable for the whole job.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle job-completion pulse.
REQ-016 The block SHALL have port perf_stall_cnt, output, 16 bits: stalled-cycle count for the current job.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-018 In IDLE, start=1 SHALL latch countdown into the step counter and iprecision/wprecision into iprec_q/wprec_q, and SHALL move to LOAD.
REQ-019 LOAD SHALL last exactly one cycle with agu_clr=1 and agu_en=0.
- Next state is RUN if the latched count is nonzero, else DONE.
REQ-020 In RUN, agu_en SHALL equal !stall combinationally; every cycle with agu_en=1 decrements the step counter by 1.
REQ-021 In RUN, a step taken with counter==1 SHALL move to DRAIN, loading the drain counter with DRAIN_LAT.
- If DRAIN_LAT==0, the step moves directly to DONE instead.
- Exactly countdown agu_en pulses SHALL occur per job.
REQ-022 DRAIN SHALL hold agu_en=0, ignore stall, decrement the drain counter each cycle, and move to DONE when the counter reaches 1.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
- Back-to-back jobs: start may be accepted on the cycle after DONE.
REQ-024 Latency: start sampled at cycle t gives agu_clr at t+1 and the first agu_en at t+2 (if stall=0).
REQ-025 start outside IDLE SHALL be ignored, with no queuing.
REQ-026 abort=1 in LOAD, RUN or DRAIN SHALL force IDLE next cycle.
- agu_clr=1 and agu_en=0 on the abort cycle.
- No done pulse is produced.
- abort has priority over stall and over normal transitions.
- abort in IDLE or DONE is ignored.
REQ-027 The step counter SHALL be BCNT bits wide and never underflow; countdown=2^BCNT-1 SHALL produce exactly that many steps.
REQ-028 iprec_q and wprec_q SHALL change only on an accepted start.

Reset
REQ-029 clr=1 at any rising edge SHALL force IDLE, including mid-job.
- Step and drain counters = 0.
- iprec_q = wprec_q = 0.
- perf_stall_cnt = 0.
- busy = done = agu_en = 0.
REQ-030 agu_clr SHALL be 1 while clr=1, so the address generator clears with the controller.

Configuration
REQ-031 With MVU_JOB_CTRL_PERFCNT_EN defined, perf_stall_cnt SHALL:
- clear on an accepted start;
- increment on each RUN cycle with stall=1 and no abort;
- saturate at 16'hFFFF;
- hold after DONE or abort.
REQ-032 Without MVU_JOB_CTRL_PERFCNT_EN, perf_stall_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-033 clr, then start with countdown=4, stall=0, DRAIN_LAT=3 -> agu_clr at t+1, agu_en at t+2..t+5, done at t+9, busy t+1..t+9.
REQ-034 countdown=0 -> LOAD then DONE, with zero agu_en pulses and done at t+2.
REQ-035 countdown=5 with stall high for 3 RUN cycles -> exactly 5 agu_en pulses, done delayed 3 cycles, perf_stall_cnt=3 with PERFCNT_EN (0 without).
REQ-036 abort on the 2nd RUN cycle -> agu_clr=1 that cycle, IDLE next, no done pulse; a new start is accepted immediately after.
REQ-037 start re-asserted during RUN with different precisions -> ignored, iprec_q/wprec_q unchanged, step count unchanged.
REQ-038 clr pulsed mid-DRAIN -> all outputs at reset values next cycle, no done pulse.
